// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard requests from ID/EX/MEM in, pipeline
// enables/flushes and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // Hazard and handshake requests
  logic             Stall;
  logic             Branch;
  logic             Jump;
  logic             MDStart;
  logic             MDDone;
  logic             DMemReq;
  logic             DMemReady;
  // Pipeline register controls
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             EXMEMWrite;
  logic             EXMEMFlush;
  logic             MEMWBWrite;
  // Status and performance counters
  logic             MDError;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  // Controller side: consumes requests, produces controls
  modport slave (
    input  Stall, Branch, Jump, MDStart, MDDone, DMemReq, DMemReady,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMWrite, EXMEMFlush,
           MEMWBWrite, MDError, StallCount, FlushCount
  );

  // Pipeline side: raises requests, obeys controls
  modport master (
    output Stall, Branch, Jump, MDStart, MDDone, DMemReq, DMemReady,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMWrite, EXMEMFlush,
           MEMWBWrite, MDError, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Enables and
// flushes are decoded combinationally from the registered state and the
// current hazard requests; state, counters and the timeout flag are registered.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MD_TIMEOUT  = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int          MD_W      = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [3:0]  INIT_LOAD = 4'(INIT_CYCLES - 1);
  localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_MDWAIT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       init_cnt_q, init_cnt_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic             md_err_q, md_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s;
  logic exmem_write_s, exmem_flush_s, memwb_write_s;
  logic mem_wait_s, apply_id_s, flush_evt_s;

  assign mem_wait_s = hz.DMemReq & ~hz.DMemReady;

  // Decode pipeline controls and next state from state and hazard requests
  always_comb begin
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_write_s = 1'b1;
    exmem_flush_s = 1'b0;
    memwb_write_s = 1'b1;
    apply_id_s    = 1'b0;
    flush_evt_s   = 1'b0;
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    md_cnt_d      = md_cnt_q;
    md_err_d      = md_err_q;

    case (state_q)
      S_INIT: begin
        pc_write_s    = 1'b0;
        ifid_write_s  = 1'b0;
        exmem_write_s = 1'b0;
        memwb_write_s = 1'b0;
        ifid_flush_s  = 1'b1;
        idex_flush_s  = 1'b1;
        exmem_flush_s = 1'b1;
        if (init_cnt_q == 4'd0) begin
          state_d = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q - 4'd1;
        end
      end
      S_RUN: begin
        if (mem_wait_s) begin
          // Memory stall freezes every stage in place
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          exmem_write_s = 1'b0;
          memwb_write_s = 1'b0;
          state_d       = S_MEMWAIT;
        end else if (hz.MDStart && !hz.MDDone) begin
          // Multi-cycle op holds front end, bubbles into MEM
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          exmem_flush_s = 1'b1;
          md_cnt_d      = '0;
          state_d       = S_MDWAIT;
        end else begin
          apply_id_s = 1'b1;
        end
      end
      S_MEMWAIT: begin
        if (hz.DMemReady) begin
          apply_id_s = 1'b1;
          state_d    = S_RUN;
        end else begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          exmem_write_s = 1'b0;
          memwb_write_s = 1'b0;
        end
      end
      S_MDWAIT: begin
        if (mem_wait_s) begin
          // Memory wait dominates; MD counter holds
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          exmem_write_s = 1'b0;
          memwb_write_s = 1'b0;
        end else if (hz.MDDone) begin
          // Result captured into EX/MEM, front end resumes
          apply_id_s = 1'b1;
          state_d    = S_RUN;
        end else begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          exmem_flush_s = 1'b1;
          if (md_cnt_q == MD_LAST) begin
            md_err_d = 1'b1;
            state_d  = S_RUN;
          end else begin
            md_cnt_d = md_cnt_q + MD_W'(1);
          end
        end
      end
      default: begin
        pc_write_s    = 1'b0;
        ifid_write_s  = 1'b0;
        exmem_write_s = 1'b0;
        memwb_write_s = 1'b0;
        ifid_flush_s  = 1'b1;
        idex_flush_s  = 1'b1;
        exmem_flush_s = 1'b1;
        state_d       = S_INIT;
      end
    endcase

    // ID-side hazards: load-use stall beats redirect (operands not ready)
    if (apply_id_s) begin
      if (hz.Stall) begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        idex_flush_s = 1'b1;
      end else if (hz.Branch || hz.Jump) begin
        ifid_flush_s = 1'b1;
        flush_evt_s  = 1'b1;
      end else begin
        flush_evt_s = 1'b0;
      end
    end else begin
      flush_evt_s = 1'b0;
    end
  end

  // Saturating performance counter next values
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_evt_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, counters and sticky timeout flag
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= S_INIT;
      init_cnt_q  <= INIT_LOAD;
      md_cnt_q    <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      md_cnt_q    <= md_cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.PCWrite    = pc_write_s;
  assign hz.IFIDWrite  = ifid_write_s;
  assign hz.IFIDFlush  = ifid_flush_s;
  assign hz.IDEXFlush  = idex_flush_s;
  assign hz.EXMEMWrite = exmem_write_s;
  assign hz.EXMEMFlush = exmem_flush_s;
  assign hz.MEMWBWrite = memwb_write_s;
  assign hz.MDError    = md_err_q;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push
// expected controls/counters; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  // Control vector order: PCWrite IFIDWrite IFIDFlush IDEXFlush EXMEMWrite EXMEMFlush MEMWBWrite
  localparam logic [6:0] C_INIT = 7'b0011010;
  localparam logic [6:0] C_RUN  = 7'b1100101;
  localparam logic [6:0] C_FRZ  = 7'b0000000;
  localparam logic [6:0] C_STL  = 7'b0001101;
  localparam logic [6:0] C_BR   = 7'b1110101;
  localparam logic [6:0] C_MD   = 7'b0000111;

  // Input vector order: Stall Branch Jump MDStart MDDone DMemReq DMemReady
  localparam logic [6:0] I_NONE  = 7'b0000000;
  localparam logic [6:0] I_STALL = 7'b1000000;
  localparam logic [6:0] I_BR    = 7'b0100000;
  localparam logic [6:0] I_JMP   = 7'b0010000;
  localparam logic [6:0] I_MDS   = 7'b0001000;
  localparam logic [6:0] I_MDD   = 7'b0000100;
  localparam logic [6:0] I_REQ   = 7'b0000010;
  localparam logic [6:0] I_RDY   = 7'b0000001;

  typedef struct {
    logic [6:0]  ctl;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
    string       tag;
  } exp_t;

  logic Clk;
  logic ResetN;
  int   checks;
  int   errors;
  logic [15:0] exp_sc;
  logic [15:0] exp_fc;
  exp_t sb[$];

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz();

  pipeline_hazard_ctrl #(
    .INIT_CYCLES(4),
    .MD_TIMEOUT (64),
    .CNT_W      (16)
  ) dut (
    .Clk   (Clk),
    .ResetN(ResetN),
    .hz    (hz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of inputs and queue the hand-derived response
  task automatic step(input logic rstn, input logic [6:0] in_v,
                      input logic [6:0] ctl, input logic err, input string tag);
    exp_t e;
    @(posedge Clk);
    #1;
    ResetN = rstn;
    {hz.Stall, hz.Branch, hz.Jump, hz.MDStart, hz.MDDone, hz.DMemReq, hz.DMemReady} = in_v;
    if (!rstn) begin
      exp_sc = 16'd0;
      exp_fc = 16'd0;
    end
    e.ctl = ctl;
    e.err = err;
    e.sc  = exp_sc;
    e.fc  = exp_fc;
    e.tag = tag;
    sb.push_back(e);
    if (rstn) begin
      if (!ctl[6] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      if (ctl[6] && ctl[4] && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge Clk) begin
    exp_t e;
    logic [6:0] act;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.IDEXFlush,
             hz.EXMEMWrite, hz.EXMEMFlush, hz.MEMWBWrite};
      checks = checks + 1;
      if (act !== e.ctl || hz.MDError !== e.err ||
          hz.StallCount !== e.sc || hz.FlushCount !== e.fc) begin
        errors = errors + 1;
        $display("FAIL %s: got ctl=%b err=%b sc=%0d fc=%0d, expected ctl=%b err=%b sc=%0d fc=%0d",
                 e.tag, act, hz.MDError, hz.StallCount, hz.FlushCount,
                 e.ctl, e.err, e.sc, e.fc);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    exp_sc = 16'd0;
    exp_fc = 16'd0;
    ResetN = 1'b0;
    {hz.Stall, hz.Branch, hz.Jump, hz.MDStart, hz.MDDone, hz.DMemReq, hz.DMemReady} = 7'b0000000;

    // Reset held, then the 4-cycle hold window
    step(1'b0, I_STALL | I_BR, C_INIT, 1'b0, "rst_hold");
    step(1'b0, I_NONE,         C_INIT, 1'b0, "rst_hold2");
    for (int i = 0; i < 4; i++) step(1'b1, I_STALL | I_MDS, C_INIT, 1'b0, "init_win");
    step(1'b1, I_NONE, C_RUN, 1'b0, "run_after_init");

    // Load-use stall, stall beating branch, redirects
    step(1'b1, I_STALL,        C_STL, 1'b0, "stall");
    step(1'b1, I_NONE,         C_RUN, 1'b0, "post_stall");
    step(1'b1, I_STALL | I_BR, C_STL, 1'b0, "stall_over_branch");
    step(1'b1, I_BR,           C_BR,  1'b0, "branch");
    step(1'b1, I_JMP,          C_BR,  1'b0, "jump");
    step(1'b1, I_NONE,         C_RUN, 1'b0, "post_jump");

    // Mul/div finishing 5 cycles after start
    step(1'b1, I_MDS, C_MD, 1'b0, "md_start");
    for (int i = 0; i < 4; i++) step(1'b1, I_NONE, C_MD, 1'b0, "md_wait");
    step(1'b1, I_MDD,  C_RUN, 1'b0, "md_capture");
    step(1'b1, I_NONE, C_RUN, 1'b0, "md_back_run");

    // Capture cycle with a concurrent branch; single-cycle op
    step(1'b1, I_MDS,         C_MD,  1'b0, "md_start2");
    step(1'b1, I_MDD | I_BR,  C_BR,  1'b0, "md_capture_branch");
    step(1'b1, I_MDS | I_MDD, C_RUN, 1'b0, "md_single_cycle");
    step(1'b1, I_NONE,        C_RUN, 1'b0, "md_single_no_wait");

    // Memory wait from RUN, dominating MDStart and Stall
    step(1'b1, I_REQ,                   C_FRZ, 1'b0, "mem_freeze");
    step(1'b1, I_NONE,                  C_FRZ, 1'b0, "memwait_hold");
    step(1'b1, I_STALL | I_RDY,         C_STL, 1'b0, "memwait_ready_stall");
    step(1'b1, I_REQ | I_MDS | I_STALL, C_FRZ, 1'b0, "mem_over_md");
    step(1'b1, I_RDY,                   C_RUN, 1'b0, "memwait_ready");
    step(1'b1, I_NONE,                  C_RUN, 1'b0, "post_mem");

    // Timeout with a 3-cycle memory freeze inside MDWAIT
    step(1'b1, I_MDS, C_MD, 1'b0, "to_start");
    for (int i = 0; i < 10; i++) step(1'b1, I_NONE, C_MD,  1'b0, "to_wait_a");
    for (int i = 0; i < 3; i++)  step(1'b1, I_REQ,  C_FRZ, 1'b0, "to_mem_freeze");
    for (int i = 0; i < 54; i++) step(1'b1, I_NONE, C_MD,  1'b0, "to_wait_b");
    step(1'b1, I_NONE,  C_RUN, 1'b1, "to_error_run");
    step(1'b1, I_STALL, C_STL, 1'b1, "to_sticky");
    step(1'b1, I_MDD,   C_RUN, 1'b1, "stray_mddone");

    // Reset dropped mid-MEMWAIT, then recovery
    step(1'b1, I_REQ, C_FRZ,  1'b1, "enter_memwait");
    step(1'b0, I_REQ, C_INIT, 1'b0, "async_reset");
    for (int i = 0; i < 4; i++) step(1'b1, I_NONE, C_INIT, 1'b0, "reinit_win");
    step(1'b1, I_BR, C_BR, 1'b0, "reinit_branch");
    step(1'b1, I_NONE, C_RUN, 1'b0, "final_run");

    repeat (3) @(negedge Clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Takes hazard requests from the ID stage (load-use Stall, Branch, Jump), multi-cycle ALU handshakes and data-memory wait.
- Drives write-enables and flushes for the PC and every pipeline register.
- Owns a post-reset hold window and saturating stall/flush performance counters.

Parameters:
- INIT_CYCLES, 4: cycles the pipeline is frozen after reset release; valid range 1..15.
- MD_TIMEOUT, 64: maximum MDWAIT cycles before MDError is raised.
- CNT_W, 16: width of the performance counters.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Stall  in  1  load-use hazard from ID.
- Branch  in  1  taken branch resolved in ID.
- Jump  in  1  jump decoded in ID.
- MDStart  in  1  multi-cycle mul/div op is in EX this cycle.
- MDDone  in  1  multi-cycle unit result valid.
- DMemReq  in  1  MEM stage is accessing data memory.
- DMemReady  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  zero the IF/ID instruction (becomes nop).
- IDEXFlush  out  1  insert bubble into ID/EX (control bits cleared).
- EXMEMWrite  out  1  EX/MEM register enable.
- EXMEMFlush  out  1  insert bubble into EX/MEM.
- MEMWBWrite  out  1  MEM/WB register enable.
- MDError  out  1  sticky mul/div timeout flag.
- StallCount  out  CNT_W  cycles in which PCWrite was 0.
- FlushCount  out  CNT_W  redirect events taken.

Behaviour:
- State register with states INIT, RUN, MEMWAIT, MDWAIT. Outputs are combinational from state and inputs in the same cycle. State, counters and MDError are registered.
- Reset (ResetN=0, asynchronous):
  - state=INIT, init counter=INIT_CYCLES-1, MD counter=0, MDError=0, StallCount=0, FlushCount=0.
  - While held in reset, outputs take their INIT values (below).
  - Reset mid-MDWAIT or mid-MEMWAIT aborts immediately.
- INIT:
  - All write-enables are 0. IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1.
  - Counter decrements each cycle; the cycle counter==0 goes to RUN.
  - All other inputs are ignored.
- Decision priority in RUN, highest first:
  1. MEM wait: DMemReq & ~DMemReady. Freeze all stages: every Write=0, no flushes. Next state is MEMWAIT.
  2. MDStart & ~MDDone. PCWrite=IFIDWrite=0. EXMEMFlush=1 (bubble into MEM). MEMWBWrite=1. Next state is MDWAIT with MD counter=0.
  3. Stall. PCWrite=IFIDWrite=0, IDEXFlush=1, remaining stages advance. Branch/Jump are ignored that cycle because operands are not yet valid.
  4. Branch|Jump. All enables 1, IFIDFlush=1. FlushCount increments.
  5. Otherwise all Write=1 and all flushes 0.
- MEMWAIT:
  - Same freeze as RUN case 1 while DMemReady=0.
  - On DMemReady=1: that cycle all Write=1 and RUN's ID-side decision (cases 3–5) applies; next state is RUN.
- MDWAIT:
  - PCWrite=IFIDWrite=0, EXMEMFlush=1, MEMWBWrite=1. MD counter increments each cycle.
  - On MDDone=1: EX/MEM captures the result (EXMEMWrite=1, EXMEMFlush=0), PC and IF/ID resume, next state is RUN. ID-side cases 3–5 apply in the same cycle.
  - MEM wait seen while in MDWAIT freezes everything that cycle (MEM wait dominates); state stays MDWAIT and the MD counter holds.
  - If MD counter reaches MD_TIMEOUT-1 without MDDone: MDError is set (sticky until reset) and the state forces RUN.
- Where the rules above do not drive an enable, EXMEMWrite=1 and MEMWBWrite=1. Exception: in INIT and under MEM-wait freeze, all Write outputs are 0.
- StallCount increments in every cycle with PCWrite=0, including INIT. Both counters saturate at all-ones and never wrap.
- Simultaneous MDStart & MDDone in RUN is a single-cycle op: no MDWAIT entry, normal advance.

Test Plan:
- Release ResetN with INIT_CYCLES=4 → PCWrite=0 for exactly 4 cycles, IFIDFlush=1 throughout, RUN on cycle 5, StallCount=4.
- In RUN, Stall=1 for one cycle → PCWrite=0, IFIDWrite=0, IDEXFlush=1, EXMEMWrite=1; next cycle all enables 1; StallCount increments by 1.
- Stall=1 and Branch=1 together → stall response only, FlushCount unchanged. Next cycle Branch=1, Stall=0 → IFIDFlush=1 and FlushCount increments by 1.
- MDStart=1, MDDone arriving 5 cycles later → 5 cycles of PCWrite=0 with EXMEMFlush=1, then a capture cycle with EXMEMWrite=1, then RUN. MDDone never asserted with MD_TIMEOUT=64 → MDError=1 after 64 cycles and return to RUN.
- DMemReq=1, DMemReady=0 for 3 cycles, asserted in MDWAIT → all Write=0 those cycles, MD counter frozen, MDWAIT resumes afterwards.
- Drop ResetN mid-MEMWAIT → outputs go to INIT values immediately with no clock edge; MDError=0 and both counters=0.
